set_bit_arbiter: RTL
====================

// Module: set_bit_arbiter
// PURPOSE
// Schedules the shared set_bit bitstream writer among frame-level stream sources: frame header, matrix, picture header, slice size table, slice header and slice data.
// Grants sources one at a time in fixed bitstream order and forwards the granted source's words onto a single registered sb_* port.
// Tracks the running bit count and records the start bit offset of each segment, so size fields can be patched later.
// Ends each frame with one flush cycle that byte-aligns the stream.
// PARAMETERS
// NUM_SRC  6   number of sources; index 0 is emitted first
// CNT_W    32  width of bit counters and offsets
// PORTS
// clock            in   1              system clock, rising edge
// reset_n          in   1              asynchronous active-low reset
// start            in   1              1-cycle pulse; begins a frame sequence
// skip_mask        in   NUM_SRC        bit i=1: source i is not granted this frame; sampled on start
// src_enable       in   NUM_SRC        per-source word valid
// src_val          in   NUM_SRC*64     per-source word, packed with source i at [64*i+:64]
// src_size_of_bit  in   NUM_SRC*64     per-source bit count; only bits [6:0] used, legal 0..64
// src_last         in   NUM_SRC        per-source end of segment
// src_grant        out  NUM_SRC        one-hot grant, registered
// sb_enable        out  1              to set_bit
// sb_val           out  64             to set_bit
// sb_size_of_bit   out  64             to set_bit; zero-extended from 7 bits
// sb_flush         out  1              to set_bit; byte-align request
// seg_offset_bit   out  NUM_SRC*CNT_W  start bit offset of segment i
// total_bits       out  CNT_W          bits written so far in this frame
// busy             out  1              high from the edge after start until done
// done             out  1              1-cycle pulse at frame end
// protocol_err     out  1              sticky; cleared only by reset or start
// BEHAVIOUR
// - Reset: all outputs 0; FSM in IDLE; idx=0.
// - FSM states: IDLE, XFER, FLUSH, DONE.
// - IDLE, start=1: clear total_bits, seg_offset_bit and protocol_err; latch skip_mask.
//   - If any source is unskipped: go to XFER with idx = lowest unskipped index; src_grant[idx]<=1; seg_offset[idx]<=0.
//   - If all sources are skipped: go to FLUSH.
// - start while busy: ignored.
// - XFER, each cycle, with g=idx:
//   - If src_enable[g]: next edge sb_enable<=1, sb_val<=src_val[g], sb_size_of_bit<=src_size_of_bit[g][6:0].
//     Also total_bits<=total_bits+size. Otherwise sb_enable<=0, and sb_val and sb_size_of_bit are driven to 0.
//   - Latency: src_* to sb_* is exactly 1 cycle.
//   - A source may stall indefinitely. The grant is held and nothing is emitted; there is no timeout.
//   - If src_last[g] (with or without src_enable): on the same edge, the grant moves to the next unskipped index k>g.
//     Also seg_offset[k]<=updated total_bits, which includes this cycle's word. There is no bubble between segments.
//     If no such k exists: src_grant<=0 and go to FLUSH.
//   - src_last with src_enable=0 closes the segment without emitting.
// - FLUSH, one cycle: sb_flush<=1, sb_enable<=0; total_bits<=(total_bits+7)&~7.
//   If total_bits is already aligned it is unchanged.
// - DONE, one cycle: done<=1, busy<=0; go to IDLE.
//   seg_offset_bit and total_bits hold their values until the next start.
// - Protocol errors set protocol_err; the offending input has no other effect:
//   - src_enable or src_last from a non-granted source;
//   - size >64;
//   - src_size_of_bit[63:7]!=0.
//   For size >64, the arbiter forwards 64 and counts 64.
// - size_of_bit=0 with enable: forwarded, and the count is unchanged.
// - total_bits wraps modulo 2^CNT_W.
// - Skipped sources: src_grant stays 0, and their seg_offset holds the offset of the next granted segment or the pre-flush total.
// - Asserting reset_n low mid-frame aborts immediately: grant, sb_* and busy drop to 0 asynchronously.
// TESTING
// 1. No skips; each source sends one 8-bit word with last on consecutive cycles.
//    -> 6 sb words; grants 0..5 with no bubbles; seg_offset=0,8,16,24,32,40; total_bits=48; one sb_flush; done.
// 2. skip_mask=6'b010010 -> grants in the order 0,2,3,5 only; seg_offset[2] equals the bits emitted by source 0.
// 3. Source 0 emits 13 bits, all others emit 0 bits with last -> sb_flush pulses once; total_bits=16 after FLUSH.
// 4. Source 2 is granted and waits 5 cycles before enable -> src_grant held; sb_enable=0 for 5 cycles; no error.
// 5. Source 4 asserts src_enable while 1 is granted; a separate word has size=70.
//    -> protocol_err=1; source 4's word is not forwarded; the 70-bit word is forwarded and counted as 64.
// 6. reset_n low during XFER -> all outputs 0 at once; a subsequent start completes test 1 exactly.

Source files
------------

// File: rtl/set_bit_arbiter_if.sv
// rtl/set_bit_arbiter_if.sv - source-side and set_bit-side signals of the set_bit arbiter
interface set_bit_arbiter_if #(
    parameter int NUM_SRC = 6
);
    logic [NUM_SRC-1:0]    src_enable;
    logic [NUM_SRC*64-1:0] src_val;
    logic [NUM_SRC*64-1:0] src_size_of_bit;
    logic [NUM_SRC-1:0]    src_last;
    logic [NUM_SRC-1:0]    src_grant;
    logic                  sb_enable;
    logic [63:0]           sb_val;
    logic [63:0]           sb_size_of_bit;
    logic                  sb_flush;

    modport master (
        input  src_enable, src_val, src_size_of_bit, src_last,
        output src_grant, sb_enable, sb_val, sb_size_of_bit, sb_flush
    );

    modport slave (
        output src_enable, src_val, src_size_of_bit, src_last,
        input  src_grant, sb_enable, sb_val, sb_size_of_bit, sb_flush
    );
endinterface

// File: rtl/set_bit_arbiter.sv
// rtl/set_bit_arbiter.sv - grants frame stream sources in bitstream order onto one set_bit port
// Tracks bit offsets of each segment and byte-aligns the stream with a final flush cycle.
module set_bit_arbiter #(
    parameter int NUM_SRC = 6,
    parameter int CNT_W   = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [NUM_SRC-1:0]       skip_mask,
    set_bit_arbiter_if.master        bus,
    output logic [NUM_SRC*CNT_W-1:0] seg_offset_bit,
    output logic [CNT_W-1:0]         total_bits,
    output logic                     busy,
    output logic                     done,
    output logic                     protocol_err
);
    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_XFER  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [NUM_SRC-1:0]       skip_q, skip_d;
    logic [NUM_SRC-1:0]       grant_q, grant_d;
    logic                     sb_en_q, sb_en_d;
    logic [63:0]              sb_val_q, sb_val_d;
    logic [6:0]               sb_size_q, sb_size_d;
    logic                     sb_flush_q, sb_flush_d;
    logic [NUM_SRC*CNT_W-1:0] seg_q, seg_d;
    logic [CNT_W-1:0]         total_q, total_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    logic                     first_found, nxt_found;
    logic [IDX_W-1:0]         first_idx, nxt_idx;
    logic [IDX_W+5:0]         g_base;
    logic                     g_en, g_last;
    logic [63:0]              g_size;
    logic [6:0]               sz_raw, sz_eff;
    logic                     size_bad, stray;
    logic [CNT_W-1:0]         total_add, total_rnd;

    // Lowest unskipped source for a new frame, and next unskipped source after the granted one.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        nxt_found   = 1'b0;
        nxt_idx     = '0;
        for (int j = NUM_SRC - 1; j >= 0; j--) begin
            if (!skip_mask[j]) begin
                first_found = 1'b1;
                first_idx   = IDX_W'(j);
            end
            if (j > int'(idx_q) && !skip_q[j]) begin
                nxt_found = 1'b1;
                nxt_idx   = IDX_W'(j);
            end
        end
    end

    assign g_base    = {idx_q, 6'b0};
    assign g_en      = bus.src_enable[idx_q];
    assign g_last    = bus.src_last[idx_q];
    assign g_size    = bus.src_size_of_bit[g_base +: 64];
    assign sz_raw    = g_size[6:0];
    assign sz_eff    = (sz_raw > 7'd64) ? 7'd64 : sz_raw;
    assign size_bad  = (g_size[63:7] != '0) || (sz_raw > 7'd64);
    assign stray     = |((bus.src_enable | bus.src_last) & ~grant_q);
    assign total_add = total_q + (g_en ? {{(CNT_W-7){1'b0}}, sz_eff} : '0);
    assign total_rnd = total_q + CNT_W'(7);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        skip_d     = skip_q;
        grant_d    = grant_q;
        sb_en_d    = 1'b0;
        sb_val_d   = '0;
        sb_size_d  = '0;
        sb_flush_d = 1'b0;
        seg_d      = seg_q;
        total_d    = total_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    total_d = '0;
                    seg_d   = '0;
                    err_d   = 1'b0;
                    skip_d  = skip_mask;
                    busy_d  = 1'b1;
                    if (first_found) begin
                        state_d = S_XFER;
                        idx_d   = first_idx;
                        grant_d = NUM_SRC'(1) << first_idx;
                    end else begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_XFER: begin
                if (stray || (g_en && size_bad)) err_d = 1'b1;
                if (g_en) begin
                    sb_en_d   = 1'b1;
                    sb_val_d  = bus.src_val[g_base +: 64];
                    sb_size_d = sz_eff;
                end
                total_d = total_add;
                if (g_last) begin
                    // Skipped sources between here and the next grant share its start offset.
                    for (int j = 0; j < NUM_SRC; j++) begin
                        if (j > int'(idx_q) && (!nxt_found || j <= int'(nxt_idx)))
                            seg_d[j*CNT_W +: CNT_W] = total_add;
                    end
                    if (nxt_found) begin
                        idx_d   = nxt_idx;
                        grant_d = NUM_SRC'(1) << nxt_idx;
                    end else begin
                        grant_d = '0;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                sb_flush_d = 1'b1;
                total_d    = {total_rnd[CNT_W-1:3], 3'b000};
                state_d    = S_DONE;
            end
            default: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            skip_q     <= '0;
            grant_q    <= '0;
            sb_en_q    <= 1'b0;
            sb_val_q   <= '0;
            sb_size_q  <= '0;
            sb_flush_q <= 1'b0;
            seg_q      <= '0;
            total_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            skip_q     <= skip_d;
            grant_q    <= grant_d;
            sb_en_q    <= sb_en_d;
            sb_val_q   <= sb_val_d;
            sb_size_q  <= sb_size_d;
            sb_flush_q <= sb_flush_d;
            seg_q      <= seg_d;
            total_q    <= total_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.src_grant      = grant_q;
    assign bus.sb_enable      = sb_en_q;
    assign bus.sb_val         = sb_val_q;
    assign bus.sb_size_of_bit = {57'b0, sb_size_q};
    assign bus.sb_flush       = sb_flush_q;
    assign seg_offset_bit     = seg_q;
    assign total_bits         = total_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign protocol_err       = err_q;
endmodule
